// File: rtl/regfile_pkg.sv
// Shared defines for the register file: rename tag width, ROB depth and
// architectural register geometry.
package regfile_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int ROB_SIZE  = 2 ** ROB_WIDTH;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/regfile_operand.sv
// Combinational operand resolve for one source register. It produces
// either a ready value or the ROB tag the operand must wait on. The priority
// is: x0, then an idle register, then a same-cycle commit bypass, then a
// value already written back into the ROB, and finally the dependency.
module regfile_operand
  import regfile_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic [XLEN-1:0]      reg_val_i,
  input  logic                 reg_busy_i,
  input  logic [ROB_WIDTH-1:0] reg_tag_i,
  input  logic                 commit_en_i,
  input  logic [ROB_WIDTH-1:0] commit_rob_id_i,
  input  logic [XLEN-1:0]      commit_val_i,
  input  logic                 search_ready_i,
  input  logic [XLEN-1:0]      search_val_i,
  output logic [XLEN-1:0]      val_o,
  output logic                 has_dep_o,
  output logic [ROB_WIDTH-1:0] dep_o
);

  // Resolve the operand. Value and tag both stay 0 unless they are chosen.
  always_comb begin
    val_o     = '0;
    has_dep_o = 1'b0;
    dep_o     = '0;
    if (rs_i != '0) begin
      if (!reg_busy_i) begin
        val_o = reg_val_i;
      end else if (commit_en_i && (commit_rob_id_i == reg_tag_i)) begin
        val_o = commit_val_i;
      end else if (search_ready_i) begin
        val_o = search_val_i;
      end else begin
        has_dep_o = 1'b1;
        dep_o     = reg_tag_i;
      end
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags. Issue resolves rs1/rs2 to a
// value or a producing ROB tag and renames rd. Commit writes the retired
// value and clears busy only on an exact tag match. Clear drops all pending
// mappings. Lookups always see the pre-edge state.
module regfile
  import regfile_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic                 commit_en,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic                 search_ready_1,
  input  logic [31:0]          search_val_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_2,
  output logic [31:0]          rs1_val,
  output logic                 rs1_has_dep,
  output logic [ROB_WIDTH-1:0] rs1_dep,
  output logic [31:0]          rs2_val,
  output logic                 rs2_has_dep,
  output logic [ROB_WIDTH-1:0] rs2_dep
);

  logic [XLEN-1:0]      val_q  [NUM_REGS];
  logic [XLEN-1:0]      val_d  [NUM_REGS];
  logic [ROB_WIDTH-1:0] tag_q  [NUM_REGS];
  logic [ROB_WIDTH-1:0] tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;

  logic issue_en;
  logic commit_wr;

  // An instruction is renamed only when it issues, targets a real register
  // and no flush happens in the same cycle.
  assign issue_en  = dec_ready && (dec_rd != '0) && !clear;
  assign commit_wr = commit_en && (commit_reg_id != '0);

  // Next state: commit first, then clear, then issue. Issue therefore wins
  // over a commit busy-clear on the same register.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_wr) begin
      val_d[commit_reg_id] = commit_val;
      // A younger producer keeps its mapping when the tag does not match.
      if (busy_q[commit_reg_id] && (tag_q[commit_reg_id] == commit_rob_id)) begin
        busy_d[commit_reg_id] = 1'b0;
      end
    end
    if (clear) begin
      busy_d = '0;
    end
    if (issue_en) begin
      busy_d[dec_rd] = 1'b1;
      tag_d[dec_rd]  = dec_rob_id;
    end
  end

  // State register. rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign search_rob_id_1 = tag_q[dec_rs1];
  assign search_rob_id_2 = tag_q[dec_rs2];

  regfile_operand u_op1 (
    .rs_i            (dec_rs1),
    .reg_val_i       (val_q[dec_rs1]),
    .reg_busy_i      (busy_q[dec_rs1]),
    .reg_tag_i       (tag_q[dec_rs1]),
    .commit_en_i     (commit_en),
    .commit_rob_id_i (commit_rob_id),
    .commit_val_i    (commit_val),
    .search_ready_i  (search_ready_1),
    .search_val_i    (search_val_1),
    .val_o           (rs1_val),
    .has_dep_o       (rs1_has_dep),
    .dep_o           (rs1_dep)
  );

  regfile_operand u_op2 (
    .rs_i            (dec_rs2),
    .reg_val_i       (val_q[dec_rs2]),
    .reg_busy_i      (busy_q[dec_rs2]),
    .reg_tag_i       (tag_q[dec_rs2]),
    .commit_en_i     (commit_en),
    .commit_rob_id_i (commit_rob_id),
    .commit_val_i    (commit_val),
    .search_ready_i  (search_ready_2),
    .search_val_i    (search_val_2),
    .val_o           (rs2_val),
    .has_dep_o       (rs2_has_dep),
    .dep_o           (rs2_dep)
  );

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
Architectural register file with rename tags. It sits between decoder, reorder buffer and reservation stations. On issue it resolves rs1/rs2 either to a value or to a producing ROB tag, and it records the new instruction's rd→ROB-id mapping. On commit it writes the committed value, and on a flush (clear) it drops every pending mapping.

Parameters:
ROB_WIDTH, 4, tag width; taken from the shared defines, and `ROB_SIZE = 2**ROB_WIDTH`.

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
rdy_in  in  1  pause when low; no state change
clear  in  1  flush from ROB, valid when rdy_in
dec_ready  in  1  decoder issues one instruction this cycle
dec_rs1  in  5  source register 1
dec_rs2  in  5  source register 2
dec_rd  in  5  destination register
dec_rob_id  in  ROB_WIDTH  ROB slot allocated to the issuing instruction (ROB empty_rob_id)
commit_en  in  1  one-cycle strobe: ROB retires a register-writing instruction
commit_rob_id  in  ROB_WIDTH  retiring slot
commit_reg_id  in  5  retiring rd
commit_val  in  32  retiring value
search_rob_id_1  out  ROB_WIDTH  tag of dec_rs1, sent to ROB
search_ready_1  in  1  ROB slot has a written-back value
search_val_1  in  32  that value
search_rob_id_2  out  ROB_WIDTH  tag of dec_rs2
search_ready_2  in  1  as above
search_val_2  in  32  as above
rs1_val  out  32  operand 1 value (valid when !rs1_has_dep)
rs1_has_dep  out  1  operand 1 waits on a ROB tag
rs1_dep  out  ROB_WIDTH  tag to wait on
rs2_val  out  32  as above
rs2_has_dep  out  1  as above
rs2_dep  out  ROB_WIDTH  as above

Behaviour:
- State per register x0..x31: val[32], busy[1], tag[ROB_WIDTH].
- Reset (async, rst_in=1): all val, busy and tag are 0. All outputs are combinational from state and inputs, so in reset rs*_val=0, rs*_has_dep=0, rs*_dep=0 and search_rob_id_*=0.
- search_rob_id_N = tag[dec_rsN], combinational.
- Lookup is combinational, with zero latency. For each operand N, the priority is:
  1. rsN==0 → val 0, no dep.
  2. !busy[rsN] → val[rsN], no dep.
  3. commit_en && commit_rob_id==tag[rsN] → commit_val, no dep. This is the same-cycle bypass.
  4. search_ready_N → search_val_N, no dep.
  5. Otherwise has_dep=1 and dep=tag[rsN]; rs*_val is don't-care but is driven to 0.
- Lookup always sees pre-edge state. An instruction whose rd equals rs1 or rs2 sees the old mapping (e.g. addi x1,x1,1 depends on the previous x1 producer).
- Sequential updates happen only on posedge with rdy_in=1. Evaluation order:
  - Commit: if commit_en && commit_reg_id!=0, write val[commit_reg_id] <= commit_val. If busy && tag==commit_rob_id, also set busy <= 0. If the tag mismatches (a younger producer exists), busy and tag are kept.
  - Issue: if dec_ready && dec_rd!=0 && !clear, set busy[dec_rd] <= 1 and tag[dec_rd] <= dec_rob_id.
  - Issue overrides the commit busy-clear on the same register in the same cycle. The value write still happens.
- clear && rdy_in: all busy <= 0 and the issue is ignored. A commit_en arriving in the same cycle still writes its value.
- x0: never written and never busy.
- rdy_in=0: no state change. Outputs keep tracking the inputs combinationally.
- Tag wrap-around is safe because busy is cleared only on a commit_en strobe with an exact tag match. The ROB guarantees a slot is not reallocated before it retires.

Decomposition:
- ROB_WIDTH and ROB_SIZE stay in the shared defines file; no new typedefs are needed.
- One sub-module, `regfile_operand`, holds the combinational 5-way resolve for one operand. It is instantiated twice (rs1 and rs2).

Test Plan:
- After reset, dec_rs1=5, dec_rs2=0 → rs1_val=0, rs1_has_dep=0, rs2_val=0; no busy bit set.
- Issue rd=3 with rob_id=2. Next cycle, lookup rs1=3 with search_ready_1=0 → rs1_has_dep=1, rs1_dep=2, search_rob_id_1=2. Raise search_ready_1 with search_val_1=0x55 → rs1_val=0x55, has_dep=0.
- Commit rob_id=2, reg 3, val 0xDEAD with commit_en=1, and lookup rs1=3 in the same cycle → bypass gives 0xDEAD with no dep. Next cycle busy[3]=0 and val[3]=0xDEAD.
- Issue rd=3 (tag 2), then rd=3 (tag 5), then commit tag 2 val 7 → val[3]=7 but busy[3]=1 and tag=5; lookup rs1=3 shows dep 5.
- Same cycle: commit tag 5 for reg 3 and issue rd=3 tag 6 → busy[3]=1, tag[3]=6, val[3]=commit_val.
- With x4 busy (tag 1), assert clear, dec_ready=1, dec_rd=8 → next cycle no register is busy and x8 is not renamed. Separately, assert rst_in mid-run → asynchronous clear to 0 without waiting for a clock edge.
